// File: rtl/i2s_pkg.sv
// Shared I2S types, default widths and slot-alignment helper.
// stereo_t is sized by the package defaults; left_align works for any width up to 64.
package i2s_pkg;

    localparam int DW_DEFAULT     = 32;
    localparam int SLOT_W_DEFAULT = 32;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] ch1;
        logic [DW_DEFAULT-1:0] ch0;
    } stereo_t;

    // Moves a right-justified dw-bit sample to the top of a slot_w-bit slot, zero padded.
    function automatic logic [63:0] left_align(input logic [63:0] word, input int dw, input int slot_w);
        return word << (slot_w - dw);
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Synchroniser plus history flop, emitting one-clk rise/fall strobes.
// level is aligned with the strobes; pin-to-strobe latency is STAGES+1 clk.
module i2s_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~hist_q;
            fall   <= ~sync_q[STAGES-1] & hist_q;
        end
    end

    assign level = hist_q;

endmodule

// File: rtl/i2s_slave_transceiver.sv
// I2S slave (left-justified, MSB first): rx words delivered 1 clk after frame end, valid/ready with overrun flag;
// tx frame taken at frame start via tx_valid/tx_ready, underrun sends zeros. I2S_SLAVE_ERR_CNT_EN adds err_cnt.
module i2s_slave_transceiver
    import i2s_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int SLOT_W      = SLOT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sck_in,
    input  logic          ws_in,
    input  logic          sdin,
    output logic          sdout,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [DW-1:0] rx_data1,
    output logic [DW-1:0] rx_data0,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic [DW-1:0] tx_data1,
    input  logic [DW-1:0] tx_data0,
    output logic          locked,
`ifdef I2S_SLAVE_ERR_CNT_EN
    output logic [15:0]   err_cnt,
`endif
    output logic          frame_err,
    output logic          overrun,
    output logic          underrun
);

    localparam int CW = $clog2(SLOT_W + 2);

    logic sck_level_unused, ws_level_unused, sd_level;
    logic sck_rise, sck_fall, ws_rise, ws_fall;
    logic sd_rise_unused, sd_fall_unused;

    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rst(rst), .din(sck_in), .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall));
    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_ws (
        .clk(clk), .rst(rst), .din(ws_in), .level(ws_level_unused), .rise(ws_rise), .fall(ws_fall));
    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_sd (
        .clk(clk), .rst(rst), .din(sdin), .level(sd_level), .rise(sd_rise_unused), .fall(sd_fall_unused));

    logic [CW-1:0]       bit_cnt;
    logic [DW-1:0]       rx_sr, half1_q, half0_q;
    logic                load_pend;
    logic [2*SLOT_W-1:0] tx_sr, tx_load;
    logic                frame_start, half_bad, fe_evt, ovr_evt, und_evt;

    assign frame_start = ws_fall & sck_fall;
    assign half_bad    = (bit_cnt != CW'(SLOT_W));
    assign fe_evt      = locked & (ws_rise | ws_fall) & half_bad;
    assign ovr_evt     = load_pend & rx_valid & ~rx_ready;
    assign und_evt     = frame_start & locked & ~tx_valid;
    assign tx_ready    = frame_start & tx_valid;
    assign sdout       = tx_sr[2*SLOT_W-1];
    assign tx_load     = {SLOT_W'(left_align(64'(tx_data1), DW, SLOT_W)),
                          SLOT_W'(left_align(64'(tx_data0), DW, SLOT_W))};

    // Receive: halves close on ws edges; the frame is published one clk after ws_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            half1_q   <= '0;
            half0_q   <= '0;
            load_pend <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data1  <= '0;
            rx_data0  <= '0;
        end else begin
            if (ws_rise) begin
                half1_q <= rx_sr;
                rx_sr   <= '0;
                bit_cnt <= '0;
            end else if (ws_fall) begin
                half0_q <= rx_sr;
                rx_sr   <= '0;
                bit_cnt <= '0;
            end else if (sck_rise) begin
                if (bit_cnt < CW'(DW))
                    rx_sr <= {rx_sr[DW-2:0], sd_level};
                if (bit_cnt != CW'(SLOT_W + 1))
                    bit_cnt <= bit_cnt + 1'b1;
            end
            load_pend <= ws_fall & locked;
            if (load_pend) begin
                rx_data1 <= half1_q;
                rx_data0 <= half0_q;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Transmit shift register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr     <= '0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (frame_start)
                tx_sr <= tx_valid ? tx_load : '0;
            else if (sck_fall)
                tx_sr <= tx_sr << 1;
            if (frame_start)
                locked <= 1'b1;
            frame_err <= fe_evt;
            if (ovr_evt)
                overrun <= 1'b1;
            if (und_evt)
                underrun <= 1'b1;
        end
    end

`ifdef I2S_SLAVE_ERR_CNT_EN
    logic [16:0] err_sum;

    always_comb begin
        err_sum = 17'(err_cnt) + 17'(fe_evt) + 17'(ovr_evt) + 17'(und_evt);
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif

endmodule
